// File: rtl/lfsr_period_monitor_pkg.sv
// Shared types for the LFSR period monitor: FSM encoding and the expected-period helper.
package lfsr_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } mon_state_e;

  // A full-length sequence that includes the all-zero state revisits zero every 2**width samples.
  function automatic int EXPECTED_PERIOD(input int width);
    return 1 << width;
  endfunction

endpackage

// File: rtl/lfsr_period_monitor_if.sv
// Sample stream in, run control in, status/result out for the LFSR period monitor.
interface lfsr_period_monitor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             busy;
  logic             done;
  logic             pass;
  logic             err_early;
  logic             err_late;
  logic             err_dup;
  logic [WIDTH:0]   last_period;
  logic [7:0]       periods_seen;

  modport master (
    output start, in_valid, in_data,
    input  busy, done, pass, err_early, err_late, err_dup, last_period, periods_seen
  );

  modport slave (
    input  start, in_valid, in_data,
    output busy, done, pass, err_early, err_late, err_dup, last_period, periods_seen
  );
endinterface

// File: rtl/lfsr_period_monitor_seen_map.sv
// One bit per possible sample value; reports whether the current value was already seen.
module lfsr_seen_map
  import lfsr_mon_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             set,
  input  logic [WIDTH-1:0] index,
  output logic             hit
);

  localparam int N = EXPECTED_PERIOD(WIDTH);

  logic [N-1:0] map_q, map_d;

  always_comb begin
    map_d = map_q;
    if (clear)    map_d        = '0;
    else if (set) map_d[index] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) map_q <= '0;
    else      map_q <= map_d;
  end

  assign hit = map_q[index];

endmodule

// File: rtl/lfsr_period_monitor.sv
// On-chip BIST checker: verifies zero recurs exactly every 2**WIDTH accepted samples for PERIODS periods.
// Optional duplicate-value detection within a period is enabled by defining LFSR_MON_DUP_CHECK_EN.
module lfsr_period_monitor
  import lfsr_mon_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int PERIODS = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  lfsr_period_monitor_if.slave mon
);

  localparam int             EXP    = EXPECTED_PERIOD(WIDTH);
  localparam logic [WIDTH:0] EXP_W  = (WIDTH+1)'(EXP);
  localparam logic [WIDTH:0] LAST_W = (WIDTH+1)'(EXP - 1);
  localparam logic [WIDTH:0] ONE_W  = (WIDTH+1)'(1);
  localparam logic [7:0]     PER_W  = 8'(PERIODS);

  mon_state_e     state_q, state_d;
  logic [WIDTH:0] cnt_q, cnt_d, cnt_inc;
  logic [WIDTH:0] lp_q, lp_d;
  logic [7:0]     ps_q, ps_d, ps_inc;
  logic           early_q, early_d;
  logic           late_q, late_d;
  logic           dup_q, dup_d;
  logic           pass_q, pass_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic acc, is_zero;
  logic map_clr, map_set, map_hit;

  assign acc     = mon.in_valid;
  assign is_zero = (mon.in_data == '0);
  assign cnt_inc = cnt_q + ONE_W;
  assign ps_inc  = ps_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lp_d    = lp_q;
    ps_d    = ps_q;
    early_d = early_q;
    late_d  = late_q;
    dup_d   = dup_q;
    pass_d  = pass_q;
    map_clr = 1'b0;
    map_set = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (mon.start) begin
          state_d = SYNC;
          cnt_d   = '0;
          lp_d    = '0;
          ps_d    = '0;
          early_d = 1'b0;
          late_d  = 1'b0;
          dup_d   = 1'b0;
          pass_d  = 1'b0;
        end
      end
      SYNC: begin
        if (acc) begin
          if (is_zero) begin
            state_d = MEAS;
            cnt_d   = '0;
            map_clr = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == EXP_W) begin
              late_d  = 1'b1;
              state_d = DONE;
            end
          end
        end
      end
      MEAS: begin
        if (acc) begin
          if (is_zero) begin
            lp_d    = cnt_inc;
            ps_d    = ps_inc;
            cnt_d   = '0;
            map_clr = 1'b1;
            if (cnt_inc < EXP_W) begin
              early_d = 1'b1;
              state_d = DONE;
            end else if (ps_inc == PER_W) begin
              state_d = DONE;
            end
          end else if (cnt_q == LAST_W) begin
            // Late takes priority over a duplicate on the same sample.
            late_d  = 1'b1;
            lp_d    = EXP_W;
            state_d = DONE;
          end else if (map_hit) begin
            dup_d   = 1'b1;
            state_d = DONE;
          end else begin
            cnt_d   = cnt_inc;
            map_set = 1'b1;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs are decoded from the next state so they align with the state register.
    done_d = (state_d == DONE);
    busy_d = (state_d == SYNC) || (state_d == MEAS);
    if (state_d == DONE) pass_d = ~(early_d | late_d | dup_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lp_q    <= '0;
      ps_q    <= '0;
      early_q <= 1'b0;
      late_q  <= 1'b0;
      dup_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
      ps_q    <= ps_d;
      early_q <= early_d;
      late_q  <= late_d;
      dup_q   <= dup_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef LFSR_MON_DUP_CHECK_EN
  lfsr_seen_map #(
    .WIDTH (WIDTH)
  ) u_seen_map (
    .clk   (clk),
    .rst   (rst),
    .clear (map_clr),
    .set   (map_set),
    .index (mon.in_data),
    .hit   (map_hit)
  );
`else
  logic unused_map;
  assign unused_map = map_clr ^ map_set;
  assign map_hit    = 1'b0;
`endif

  assign mon.busy         = busy_q;
  assign mon.done         = done_q;
  assign mon.pass         = pass_q;
  assign mon.err_early    = early_q;
  assign mon.err_late     = late_q;
  assign mon.err_dup      = dup_q;
  assign mon.last_period  = lp_q;
  assign mon.periods_seen = ps_q;

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Randomized bench for lfsr_period_monitor (WIDTH=4, PERIODS=2) against a stream-scanning reference model.
module tb_lfsr_period_monitor;

  localparam int W   = 4;
  localparam int PER = 2;
  localparam int EXP = 16;
`ifdef LFSR_MON_DUP_CHECK_EN
  localparam bit DUP = 1'b1;
`else
  localparam bit DUP = 1'b0;
`endif

  typedef struct {
    int close;
    bit early;
    bit late;
    bit dup;
    int lp;
    int ps;
  } exp_t;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;
  logic [W-1:0] stream[$];

  lfsr_period_monitor_if #(.WIDTH(W)) intf ();

  lfsr_period_monitor #(
    .WIDTH   (W),
    .PERIODS (PER)
  ) dut (
    .clk (clk),
    .rst (rst),
    .mon (intf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // Scan the accepted-sample stream: find sync zero, then walk period by period.
  function automatic exp_t model();
    exp_t e;
    int   z, pos;
    bit   seen[EXP];
    bit   fin;
    e.close = 0; e.early = 0; e.late = 0; e.dup = 0; e.lp = 0; e.ps = 0;
    z = -1;
    for (int i = 0; i < EXP; i++)
      if (stream[i] == 0) begin z = i; break; end
    if (z < 0) begin
      e.late = 1; e.close = EXP - 1;
      return e;
    end
    pos = z;
    fin = 0;
    while (!fin) begin
      int nxt;
      nxt = -1;
      for (int v = 0; v < EXP; v++) seen[v] = 0;
      for (int j = pos + 1; j <= pos + EXP; j++) begin
        if (stream[j] == 0) begin
          e.lp = j - pos;
          e.ps++;
          if (e.lp < EXP)      begin e.early = 1; e.close = j; fin = 1; end
          else if (e.ps == PER) begin e.close = j; fin = 1; end
          else nxt = j;
          break;
        end
        if (j == pos + EXP) begin e.late = 1; e.lp = EXP; e.close = j; fin = 1; break; end
        if (DUP && seen[stream[j]]) begin e.dup = 1; e.close = j; fin = 1; break; end
        seen[stream[j]] = 1;
      end
      if (!fin) pos = nxt;
    end
    return e;
  endfunction

  // Random nonzero prefix, then four repeats of a random permutation that starts at zero.
  task automatic gen_golden(input int pre);
    logic [W-1:0] p[EXP];
    logic [W-1:0] t;
    int j;
    for (int i = 0; i < EXP; i++) p[i] = W'(i);
    for (int i = EXP - 1; i > 1; i--) begin
      j = $urandom_range(1, i);
      t = p[i]; p[i] = p[j]; p[j] = t;
    end
    stream.delete();
    for (int i = 0; i < pre; i++) stream.push_back(W'($urandom_range(1, EXP - 1)));
    for (int r = 0; r < 4; r++)
      for (int i = 0; i < EXP; i++) stream.push_back(p[i]);
  endtask

  task automatic pulse_start();
    intf.start    = 1'b1;
    intf.in_valid = 1'b0;
    intf.in_data  = W'($urandom);
    @(posedge clk); #1;
    intf.start = 1'b0;
  endtask

  // mode 0: always valid, 1: valid one cycle in three, 2: random gaps
  task automatic run(input string nm, input int mode);
    exp_t e;
    int   k;
    bit   got, v;
    int   pass_exp;
    e = model();
    pass_exp = !(e.early || e.late || e.dup);
    pulse_start();
    chk({nm, ".busy_on"}, int'(intf.busy), 1);
    k = 0;
    got = 0;
    for (int cyc = 0; cyc < 600 && !got; cyc++) begin
      v = (mode == 1) ? (cyc % 3 == 0) : (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (k >= stream.size()) v = 1'b0;
      intf.in_valid = v;
      intf.in_data  = v ? stream[k] : W'($urandom);
      @(posedge clk); #1;
      if (v) k++;
      got = intf.done;
    end
    intf.in_valid = 1'b0;
    chk({nm, ".done_seen"}, int'(got), 1);
    chk({nm, ".accepted"}, k, e.close + 1);
    chk({nm, ".err_early"}, int'(intf.err_early), int'(e.early));
    chk({nm, ".err_late"}, int'(intf.err_late), int'(e.late));
    chk({nm, ".err_dup"}, int'(intf.err_dup), int'(e.dup));
    chk({nm, ".last_period"}, int'(intf.last_period), e.lp);
    chk({nm, ".periods_seen"}, int'(intf.periods_seen), e.ps);
    chk({nm, ".pass"}, int'(intf.pass), pass_exp);
    chk({nm, ".busy_done"}, int'(intf.busy), 0);
    @(posedge clk); #1;
    chk({nm, ".done_pulse"}, int'(intf.done), 0);
    chk({nm, ".pass_hold"}, int'(intf.pass), pass_exp);
  endtask

  task automatic chk_cleared(input string nm);
    chk({nm, ".busy"}, int'(intf.busy), 0);
    chk({nm, ".done"}, int'(intf.done), 0);
    chk({nm, ".pass"}, int'(intf.pass), 0);
    chk({nm, ".err_early"}, int'(intf.err_early), 0);
    chk({nm, ".err_late"}, int'(intf.err_late), 0);
    chk({nm, ".err_dup"}, int'(intf.err_dup), 0);
    chk({nm, ".last_period"}, int'(intf.last_period), 0);
    chk({nm, ".periods_seen"}, int'(intf.periods_seen), 0);
  endtask

  initial begin
    int pre, pos, idx5;
    n_chk  = 0;
    n_pass = 0;
    rst           = 1'b0;
    intf.start    = 1'b0;
    intf.in_valid = 1'b0;
    intf.in_data  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_cleared("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // golden full-cycle stream
    gen_golden($urandom_range(0, 8));
    run("golden", 0);

    // zero forced at sample 10 after sync
    pre = $urandom_range(0, 8);
    gen_golden(pre);
    stream[pre + 10] = '0;
    run("early10", 0);

    // held at 7 after sync
    pre = $urandom_range(0, 8);
    gen_golden(pre);
    for (int i = pre + 1; i < stream.size(); i++) stream[i] = W'(7);
    run("held7", 0);

    // one valid cycle in three
    gen_golden($urandom_range(0, 8));
    run("sparse", 1);

    // reset in mid-MEASURE after one period has closed
    gen_golden(2);
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      intf.in_valid = 1'b1;
      intf.in_data  = stream[i];
      @(posedge clk); #1;
    end
    intf.in_valid = 1'b0;
    chk("midrun.periods_seen", int'(intf.periods_seen), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk_cleared("midrst");
    rst = 1'b1;
    gen_golden($urandom_range(0, 8));
    run("after_rst", 0);

    // value 5 appears twice in one period
    pre = $urandom_range(0, 8);
    gen_golden(pre);
    idx5 = 0;
    for (int i = pre + 1; i < pre + EXP; i++) if (stream[i] == W'(5)) idx5 = i;
    pos = (idx5 == pre + 1) ? pre + 2 + $urandom_range(0, 12) : pre + 1 + $urandom_range(0, idx5 - pre - 2);
    if (pos == idx5) pos = pre + EXP - 1;
    stream[pos] = W'(5);
    run("dup5", 0);

    // no zero at all before sync gives up
    gen_golden(0);
    for (int i = 0; i < stream.size(); i++) stream[i] = W'($urandom_range(1, EXP - 1));
    run("sync_late", 2);

    // randomized corruptions with random valid gaps
    for (int t = 0; t < 16; t++) begin
      gen_golden($urandom_range(0, 12));
      if ($urandom_range(0, 2) != 0)
        stream[$urandom_range(0, 40)] = W'($urandom_range(0, EXP - 1));
      if ($urandom_range(0, 3) == 0)
        stream[$urandom_range(0, 40)] = W'($urandom_range(0, EXP - 1));
      run($sformatf("rand%0d", t), 2);
    end

    // start in a busy state must be ignored
    gen_golden(1);
    pulse_start();
    intf.in_valid = 1'b1;
    intf.in_data  = stream[0];
    @(posedge clk); #1;
    intf.in_data  = stream[1];
    intf.start    = 1'b1;
    @(posedge clk); #1;
    intf.start    = 1'b0;
    intf.in_valid = 1'b0;
    chk("start_ign.busy", int'(intf.busy), 1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
